lcd_panel_sequencer: RTL

- Panel power/backlight sequencer that sits directly upstream of the LVDS/panel-control passthrough.
- Takes the iGPU panel-power and backlight requests and produces timed LCD_PWR_EN, LVDS output-enable and LCD_BKLT_EN.
- Enforces panel on/off ordering and minimum delays regardless of how the GPU toggles its requests.
- Outputs drive the panel-control pins in place of the raw request signals.

---
 rtl/lcd_panel_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lcd_panel_sequencer.sv
// Panel power / LVDS / backlight sequencer with enforced on/off ordering and minimum dwells.
// Optional request deglitch filter enabled by defining LCD_SEQ_DEGLITCH_EN.
module lcd_panel_sequencer #(
   parameter logic [23:0] T_PWR_TO_LVDS     = 24'd500000,
   parameter logic [23:0] T_LVDS_TO_BKL     = 24'd2000000,
   parameter logic [23:0] T_BKL_OFF_TO_LVDS = 24'd2000000,
   parameter logic [23:0] T_LVDS_OFF_TO_PWR = 24'd500000,
   parameter logic [23:0] T_PWR_OFF_MIN     = 24'd5000000,
   parameter logic [7:0]  DGL_CYCLES        = 8'd4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       panel_pwr_req,
   input  logic       bkl_on_req,
   output logic       lcd_pwr_en,
   output logic       lvds_out_en,
   output logic       lcd_bklt_en,
   output logic [2:0] seq_state,
   output logic       seq_busy
);

   typedef enum logic [2:0] {
      StOff     = 3'd0,
      StPwrOn   = 3'd1,
      StLvdsOn  = 3'd2,
      StBklOn   = 3'd3,
      StBklOff  = 3'd4,
      StLvdsOff = 3'd5,
      StPwrOff  = 3'd6,
      StIllegal = 3'd7
   } state_e;

   logic [1:0] pwr_sync_q, bkl_sync_q;
   logic       pwr_s, bkl_s;
   logic       pwr_f, bkl_f;

   always_ff @(posedge clk) begin
      if (rst) begin
         pwr_sync_q <= 2'b00;
         bkl_sync_q <= 2'b00;
      end else begin
         pwr_sync_q <= {pwr_sync_q[0], panel_pwr_req};
         bkl_sync_q <= {bkl_sync_q[0], bkl_on_req};
      end
   end

   assign pwr_s = pwr_sync_q[1];
   assign bkl_s = bkl_sync_q[1];

`ifdef LCD_SEQ_DEGLITCH_EN
   logic       pwr_f_q, bkl_f_q;
   logic [7:0] pwr_dgl_q, bkl_dgl_q;

   // Filtered value flips only after DGL_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwr_f_q   <= 1'b0;
         bkl_f_q   <= 1'b0;
         pwr_dgl_q <= 8'd0;
         bkl_dgl_q <= 8'd0;
      end else begin
         if (pwr_s != pwr_f_q) begin
            if (pwr_dgl_q == DGL_CYCLES - 8'd1) begin
               pwr_f_q   <= pwr_s;
               pwr_dgl_q <= 8'd0;
            end else begin
               pwr_dgl_q <= pwr_dgl_q + 8'd1;
            end
         end else begin
            pwr_dgl_q <= 8'd0;
         end
         if (bkl_s != bkl_f_q) begin
            if (bkl_dgl_q == DGL_CYCLES - 8'd1) begin
               bkl_f_q   <= bkl_s;
               bkl_dgl_q <= 8'd0;
            end else begin
               bkl_dgl_q <= bkl_dgl_q + 8'd1;
            end
         end else begin
            bkl_dgl_q <= 8'd0;
         end
      end
   end

   assign pwr_f = pwr_f_q;
   assign bkl_f = bkl_f_q;
`else
   logic unused_dgl;
   assign unused_dgl = ^DGL_CYCLES;
   assign pwr_f      = pwr_s;
   assign bkl_f      = bkl_s;
`endif

   state_e      state_q, state_d;
   logic [23:0] cnt_q, cnt_d;
   logic        cnt_zero;

   assign cnt_zero = (cnt_q == 24'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_zero ? cnt_q : cnt_q - 24'd1;
      case (state_q)
         StOff:     if (pwr_f) state_d = StPwrOn;
         StPwrOn:   if (!pwr_f) state_d = StPwrOff;
                    else if (cnt_zero) state_d = StLvdsOn;
         StLvdsOn:  if (!pwr_f) state_d = StLvdsOff;
                    else if (cnt_zero && bkl_f) state_d = StBklOn;
         StBklOn:   if (!pwr_f || !bkl_f) state_d = StBklOff;
         StBklOff:  if (cnt_zero) state_d = pwr_f ? StLvdsOn : StLvdsOff;
         StLvdsOff: if (cnt_zero) state_d = StPwrOff;
         StPwrOff:  if (cnt_zero) state_d = StOff;
         default:   state_d = StOff;
      endcase
      // Loading T-1 on entry plus exit-at-zero yields exactly T cycles of dwell.
      if (state_d != state_q) begin
         case (state_d)
            StPwrOn:   cnt_d = T_PWR_TO_LVDS - 24'd1;
            StLvdsOn:  cnt_d = T_LVDS_TO_BKL - 24'd1;
            StBklOff:  cnt_d = T_BKL_OFF_TO_LVDS - 24'd1;
            StLvdsOff: cnt_d = T_LVDS_OFF_TO_PWR - 24'd1;
            StPwrOff:  cnt_d = T_PWR_OFF_MIN - 24'd1;
            default:   cnt_d = 24'd0;
         endcase
      end
   end

   // Outputs are decoded from the next state so they switch on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StOff;
         cnt_q       <= 24'd0;
         lcd_pwr_en  <= 1'b0;
         lvds_out_en <= 1'b0;
         lcd_bklt_en <= 1'b0;
         seq_busy    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lcd_pwr_en  <= state_d inside {StPwrOn, StLvdsOn, StBklOn, StBklOff, StLvdsOff};
         lvds_out_en <= state_d inside {StLvdsOn, StBklOn, StBklOff};
         lcd_bklt_en <= (state_d == StBklOn);
         seq_busy    <= state_d inside {StPwrOn, StBklOff, StLvdsOff, StPwrOff};
      end
   end

   assign seq_state = state_q;

endmodule
